// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU; grant counters with ALU_ARB_STATS_EN.
// Latency: accept in cycle N, response valid in cycle N+2; one op in flight, 3 cycles minimum per op.
// Backpressure: result held until owner's rsp_ready; both request readies stay low outside IDLE.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt,
`endif
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_err,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } alu_op_t;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  state_t      state_q, state_d;
  alu_op_t     op_q;
  logic        owner_q;
  logic        prio_q;   // 1: requester 1 wins a tie
  logic [31:0] result_q;
  logic        err_q;
  logic        gnt0, gnt1;
  logic        supported;

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || !prio_q)) gnt0 = 1'b1;
        else if (req1_valid)                        gnt1 = 1'b1;
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign supported = op_q.op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt0 || gnt1) begin
        op_q    <= gnt1 ? '{a: req1_a, b: req1_b, op: req1_op}
                        : '{a: req0_a, b: req0_b, op: req0_op};
        owner_q <= gnt1;
        prio_q  <= gnt0;
      end
      if (state_q == EXEC) begin
        result_q <= supported ? alu_result : 32'h0;
        err_q    <= !supported;
      end
    end
  end

  // Readies are gated by reset so nothing is offered while rst_n is held low.
  assign req0_ready  = rst_n & gnt0;
  assign req1_ready  = rst_n & gnt1;
  assign rsp0_valid  = (state_q == RESP) & ~owner_q;
  assign rsp1_valid  = (state_q == RESP) & owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
  assign alu_in1     = op_q.a;
  assign alu_in2     = op_q.b;
  assign alu_sel     = op_q.op;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      if (gnt1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_a, req_b, rsp_result;
  logic [1:0][3:0]  req_op;
  logic [31:0]      alu_in1, alu_in2, alu_result;
  logic [3:0]       alu_sel;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      grant0_cnt, grant1_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared ALU seen by the DUT; unsupported codes return junk that must not leak out.
  function automatic logic [31:0] alu_env(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s);
    case (s)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_env(alu_in1, alu_in2, alu_sel);

  // Expected {err, result} for one operation.
  function automatic logic [32:0] expect_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, a + b};
      4'd6:    return {1'b0, a - b};
      4'd7:    return {1'b0, 31'd0, $signed(a) < $signed(b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  alu_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_ARB_STATS_EN
    .grant0_cnt  (grant0_cnt),
    .grant1_cnt  (grant1_cnt),
`endif
    .req0_valid  (req_valid[0]),
    .req0_ready  (req_ready[0]),
    .req0_a      (req_a[0]),
    .req0_b      (req_b[0]),
    .req0_op     (req_op[0]),
    .req1_valid  (req_valid[1]),
    .req1_ready  (req_ready[1]),
    .req1_a      (req_a[1]),
    .req1_b      (req_b[1]),
    .req1_op     (req_op[1]),
    .rsp0_valid  (rsp_valid[0]),
    .rsp0_ready  (rsp_ready[0]),
    .rsp0_result (rsp_result[0]),
    .rsp0_err    (rsp_err[0]),
    .rsp1_valid  (rsp_valid[1]),
    .rsp1_ready  (rsp_ready[1]),
    .rsp1_result (rsp_result[1]),
    .rsp1_err    (rsp_err[1]),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Drives one operation on requester id and reports what was observed along the way.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int hold, output bit acc, output bit busy_n1, output bit rv_n1,
                        output bit rv_n2, output logic [31:0] res, output logic e,
                        output bit stable, output bit idle_after);
    int w;
    acc = 0; busy_n1 = 1; rv_n1 = 1; rv_n2 = 0; res = 'x; e = 1'bx; stable = 0; idle_after = 0;
    req_a[id] = a; req_b[id] = b; req_op[id] = op; req_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 20) begin
      tick();
      w++;
    end
    acc = req_ready[id];
    if (!acc) begin
      req_valid[id] = 1'b0;
      return;
    end
    tick();
    req_valid[id] = 1'b0;
    req_a[id] = ~a;
    req_op[id] = op ^ 4'h5;
    #1;
    busy_n1 = (req_ready != 2'b00);
    rv_n1 = rsp_valid[id];
    tick();
    rv_n2 = rsp_valid[id];
    res = rsp_result[id];
    e = rsp_err[id];
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid[id] || rsp_result[id] !== res || rsp_err[id] !== e || req_ready != 2'b00) stable = 0;
    end
    rsp_ready[id] = 1'b1;
    tick();
    rsp_ready[id] = 1'b0;
    #1;
    idle_after = !rsp_valid[id];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = '{32'h1234_5678, 32'h9abc_def0};
    req_b = '{32'h1111_1111, 32'h2222_2222};
    req_op = '{4'h2, 4'h1};
    rsp_ready = 2'b00;
    tick();
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", alu_in1, alu_in2); end
    checks++; if (alu_sel !== 4'h0) begin errors++; $display("FAIL reset_alu_sel: got %h want 0", alu_sel); end
    checks++; if (rsp_result[0] !== 32'h0 || rsp_err !== 2'b00) begin errors++; $display("FAIL reset_result: got %h err %b want 0 err 00", rsp_result[0], rsp_err); end
`ifdef ALU_ARB_STATS_EN
    checks++; if (grant0_cnt !== 16'd0 || grant1_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", grant0_cnt, grant1_cnt); end
`endif
    req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_valid_ready: got %b want 00", req_ready); end
  endtask

  task automatic test_single_add();
    bit acc, busy, rv1, rv2, st, idl;
    logic [31:0] res;
    logic e;
    req_valid = 2'b00;
    run_op(0, 32'd5, 32'd3, 4'b0010, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc) begin errors++; $display("FAIL add_accept: got no grant want grant"); end
    checks++; if (busy || rv1) begin errors++; $display("FAIL add_exec_cycle: got busy=%0d rsp_valid=%0d want 0/0", busy, rv1); end
    checks++; if (!rv2) begin errors++; $display("FAIL add_latency: got rsp_valid=0 at N+2 want 1"); end
    checks++; if (res !== 32'd8 || e !== 1'b0) begin errors++; $display("FAIL add_result: got %0d err %b want 8 err 0", res, e); end
    checks++; if (!idl) begin errors++; $display("FAIL add_release: got rsp_valid=1 after ready want 0"); end
  endtask

  task automatic test_alternate();
    int w;
    logic [1:0] want;
    apply_reset();
    req_a = '{32'd10, 32'd10};
    req_b = '{32'd4, 32'd4};
    req_op = '{4'b0110, 4'b0110};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      while (req_ready == 2'b00 && w < 20) begin
        tick();
        w++;
      end
      checks++; if (req_ready !== want) begin errors++; $display("FAIL alt_grant%0d: got %b want %b", k, req_ready, want); end
      tick();
      tick();
      checks++; if (rsp_valid !== want || rsp_result[k % 2] !== 32'd6) begin
        errors++; $display("FAIL alt_rsp%0d: got valid %b result %0d want %b result 6", k, rsp_valid, rsp_result[k % 2], want);
      end
      rsp_ready = want;
      tick();
      rsp_ready = 2'b00;
      #1;
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_slt();
    bit acc, busy, rv1, rv2, st, idl;
    logic [31:0] res;
    logic e;
    run_op(1, 32'd2, 32'd9, 4'b0111, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc || !rv2 || res !== 32'd1 || e !== 1'b0) begin errors++; $display("FAIL slt_lt: got acc=%0d v=%0d %0d err %b want 1 err 0", acc, rv2, res, e); end
    run_op(1, 32'd9, 32'd2, 4'b0111, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc || !rv2 || res !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL slt_ge: got acc=%0d v=%0d %0d err %b want 0 err 0", acc, rv2, res, e); end
  endtask

  task automatic test_err();
    bit acc, busy, rv1, rv2, st, idl;
    logic [31:0] res;
    logic e;
    run_op(0, 32'd7, 32'd7, 4'b1111, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc || res !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL bad_op: got acc=%0d %h err %b want 0 err 1", acc, res, e); end
    run_op(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0000, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc || res !== 32'h0F0F_0000 || e !== 1'b0) begin errors++; $display("FAIL and_op: got acc=%0d %h err %b want 0f0f0000 err 0", acc, res, e); end
  endtask

  task automatic test_hold();
    bit acc, busy, rv1, rv2, st, idl;
    logic [31:0] res;
    logic e;
    apply_reset();
    req_a[1] = 32'd1; req_b[1] = 32'd1; req_op[1] = 4'b0001;
    req_valid[1] = 1'b1;
    run_op(0, 32'd7, 32'd7, 4'b0010, 5, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (!acc || res !== 32'd14) begin errors++; $display("FAIL hold_result: got acc=%0d %0d want 14", acc, res); end
    checks++; if (!st) begin errors++; $display("FAIL hold_stable: got unstable response or req1_ready want stable"); end
    checks++; if (!idl || req_ready !== 2'b10) begin errors++; $display("FAIL hold_release: got idle=%0d ready %b want 1 and 10", idl, req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL withdraw: got ready %b valid %b want 00 00", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int w;
    bit acc, busy, rv1, rv2, st, idl;
    logic [31:0] res;
    logic e;
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 4'b0010;
    req_valid = 2'b01;
    #1;
    w = 0;
    while (!req_ready[0] && w < 20) begin
      tick();
      w++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_outputs: got ready %b valid %b want 00 00", req_ready, rsp_valid); end
    checks++; if (alu_in1 !== 32'h0 || alu_sel !== 4'h0) begin errors++; $display("FAIL midrst_regs: got %h sel %h want 0 sel 0", alu_in1, alu_sel); end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp%0d: got %b want 00", i, rsp_valid); end
    end
`ifdef ALU_ARB_STATS_EN
    checks++; if (grant0_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", grant0_cnt); end
    run_op(0, 32'd3, 32'd4, 4'b0010, 0, acc, busy, rv1, rv2, res, e, st, idl);
    run_op(0, 32'd3, 32'd4, 4'b0001, 0, acc, busy, rv1, rv2, res, e, st, idl);
    checks++; if (grant0_cnt !== 16'd2 || grant1_cnt !== 16'd0) begin errors++; $display("FAIL cnt_after: got %0d/%0d want 2/0", grant0_cnt, grant1_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd0};
    int pref, v, win, w, hold;
    logic [1:0] oh;
    logic [31:0] ea, eb;
    logic [3:0] eop;
    logic [32:0] exp;
    int cnt [2];
    apply_reset();
    pref = 0;
    cnt = '{0, 0};
    for (int n = 0; n < 60; n++) begin
      v = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        req_a[r] = $urandom;
        req_b[r] = (n % 4 == 0) ? req_a[r] : $urandom;
        req_op[r] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
      end
      req_valid = 2'(v);
      win = (v == 1) ? 0 : (v == 2) ? 1 : pref;
      oh = (win == 0) ? 2'b01 : 2'b10;
      ea = req_a[win]; eb = req_b[win]; eop = req_op[win];
      #1;
      w = 0;
      while (req_ready == 2'b00 && w < 20) begin
        tick();
        w++;
      end
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL rnd_grant%0d: got %b want %b", n, req_ready, oh); end
      tick();
      req_valid = 2'b00;
      #1;
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rnd_exec%0d: got ready %b valid %b want 00 00", n, req_ready, rsp_valid); end
      tick();
      exp = expect_rsp(ea, eb, eop);
      checks++; if (rsp_valid !== oh || {rsp_err[win], rsp_result[win]} !== exp) begin
        errors++; $display("FAIL rnd_rsp%0d: got valid %b err %b %h want %b err %b %h", n, rsp_valid, rsp_err[win], rsp_result[win], oh, exp[32], exp[31:0]);
      end
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        rsp_ready[1 - win] = 1'($urandom);
        tick();
      end
      #1;
      checks++; if (rsp_valid !== oh || {rsp_err[win], rsp_result[win]} !== exp) begin
        errors++; $display("FAIL rnd_hold%0d: got valid %b %h want %b %h", n, rsp_valid, rsp_result[win], oh, exp[31:0]);
      end
      rsp_ready = oh;
      tick();
      rsp_ready = 2'b00;
      pref = 1 - win;
      cnt[win]++;
    end
`ifdef ALU_ARB_STATS_EN
    checks++; if (grant0_cnt !== 16'(cnt[0]) || grant1_cnt !== 16'(cnt[1])) begin
      errors++; $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", grant0_cnt, grant1_cnt, cnt[0], cnt[1]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_alternate();
    test_slt();
    test_err();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
